tick_gen: RTL and testbench

- Multi-channel fractional clock-enable generator. Each channel is a phase-accumulator NCO.
- Replaces fixed dedicated PLL outputs (UART bit clock, flash SPI clock, slow housekeeping clock) with single-cycle enables derived from the main clock.
- Sits beside the top-level integration and feeds UART, flash SPI and LED/debug logic.
- Rates are runtime-programmable per channel; all channels can be phase-aligned with one sync pulse.

---
 rtl/tick_gen_pkg.sv | 31 +++
 rtl/tick_gen_if.sv | 47 ++++
 rtl/tick_gen_nco.sv | 92 +++++++++
 rtl/tick_gen.sv | 57 +++++
 tb/tb_tick_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants, config bundle and rate helper for the tick generator.
// Optional square-wave outputs are enabled with TICK_GEN_SQWAVE_EN.
package tick_gen_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int CH_MAX    = 16;
  localparam int CH_W_MAX  = 4;

  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [ACC_W_DEF-1:0] inc;
    logic                 en;
  } cfg_t;

  // Channel-select width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment giving f_tick from f_clk, rounded to nearest.
  function automatic longint unsigned inc_for_rate(
    input longint unsigned f_clk,
    input longint unsigned f_tick,
    input int unsigned     acc_w = ACC_W_DEF
  );
    longint unsigned num;
    num = (f_tick << acc_w) + (f_clk >> 1);
    return num / f_clk;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Config/sync inputs and tick outputs of the tick generator.
// Carries the sq vector only when TICK_GEN_SQWAVE_EN is defined.
interface tick_gen_if
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = ACC_W_DEF
) ();

  localparam int CH_W = ch_w(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic              cfg_en;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] ch_active;
`ifdef TICK_GEN_SQWAVE_EN
  logic [NUM_CH-1:0] sq;

  modport master (
    output cfg_we, cfg_ch, cfg_inc,
    output cfg_en, sync,
    input  tick, ch_active, sq
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_inc,
    input  cfg_en, sync,
    output tick, ch_active, sq
  );
`else
  modport master (
    output cfg_we, cfg_ch, cfg_inc,
    output cfg_en, sync,
    input  tick, ch_active
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_inc,
    input  cfg_en, sync,
    output tick, ch_active
  );
`endif

endinterface

// File: rtl/tick_gen_nco.sv
// One phase-accumulator tick channel: acc, inc, en and registered tick.
// Square-wave register present only with TICK_GEN_SQWAVE_EN.
module tick_nco
  import tick_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             en_i,
  input  logic             sync_i,
  output logic             tick_o,
  output logic             active_o
`ifdef TICK_GEN_SQWAVE_EN
  ,
  output logic             sq_o
`endif
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             en_q, en_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum;

  // Accumulate; sync and a write both restart the phase from zero.
  always_comb begin
    acc_d  = acc_q;
    inc_d  = inc_q;
    en_d   = en_q;
    tick_d = 1'b0;
    sum    = {1'b0, acc_q} + {1'b0, inc_q};
    if (en_q) begin
      acc_d  = sum[ACC_W-1:0];
      tick_d = sum[ACC_W];
    end
    if (sync_i) begin
      acc_d  = '0;
      tick_d = 1'b0;
    end
    if (we_i) begin
      inc_d  = inc_i;
      en_d   = en_i;
      acc_d  = '0;
      tick_d = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      inc_q  <= '0;
      en_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      en_q   <= en_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o   = tick_q;
  assign active_o = en_q;

`ifdef TICK_GEN_SQWAVE_EN
  logic sq_q, sq_d;

  // Toggle once per observed tick; phase restarts with acc.
  always_comb begin
    sq_d = sq_q ^ tick_q;
    if (sync_i || we_i) begin
      sq_d = 1'b0;
    end
  end

  // Square-wave register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel fractional clock-enable generator (NUM_CH NCO channels).
// Define TICK_GEN_SQWAVE_EN to add per-channel half-rate square waves.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = ACC_W_DEF
) (
  input logic      CLK,
  input logic      RST,
  tick_gen_if.slave bus
);

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] act_w;

  // One-hot write strobes; out-of-range selects match nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cfg_we && (int'(bus.cfg_ch) == i)) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

`ifdef TICK_GEN_SQWAVE_EN
  logic [NUM_CH-1:0] sq_w;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    tick_nco #(
      .ACC_W (ACC_W)
    ) u_nco (
      .clk_i    (CLK),
      .rst_i    (RST),
      .we_i     (wr_sel[gi]),
      .inc_i    (bus.cfg_inc),
      .en_i     (bus.cfg_en),
      .sync_i   (bus.sync),
      .tick_o   (tick_w[gi]),
      .active_o (act_w[gi])
`ifdef TICK_GEN_SQWAVE_EN
      ,
      .sq_o     (sq_w[gi])
`endif
    );
  end

  assign bus.tick      = tick_w;
  assign bus.ch_active = act_w;
`ifdef TICK_GEN_SQWAVE_EN
  assign bus.sq        = sq_w;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with NUM_CH=5, ACC_W=8.
// Checks sq as well when TICK_GEN_SQWAVE_EN is defined.
module tb_tick_gen;

  localparam int NC = 5;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tick_gen_if #(.NUM_CH(NC), .ACC_W(AW)) bus ();

  tick_gen #(
    .NUM_CH (NC),
    .ACC_W  (AW)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int n0     = 0;
  bit run0   = 1'b0;
  logic [NC-1:0] ev;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock; ch0 (inc=64) expectations tracked by edge count n0.
  task automatic step(input bit clr0);
    @(posedge clk);
    #1;
    if (clr0) n0 = 0;
    else n0++;
    chk("tick0", 32'(bus.tick[0]),
        32'(run0 && n0 > 0 && n0 % 4 == 0));
`ifdef TICK_GEN_SQWAVE_EN
    chk("sq0", 32'(bus.sq[0]),
        32'(run0 && n0 > 0 && ((n0 - 1) / 4) % 2 == 1));
`endif
  endtask

  task automatic wr(input int ch, input int inc,
                    input bit en, input bit syn);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 3'(ch);
    bus.cfg_inc = 8'(inc);
    bus.cfg_en  = en;
    bus.sync    = syn;
    if (ch == 0) run0 = en;
    step(ch == 0 || syn);
    bus.cfg_we = 1'b0;
    bus.sync   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_inc = '0;
    bus.cfg_en  = 1'b0;
    bus.sync    = 1'b0;

    #12;
    chk("rst_tick", 32'(bus.tick), 32'(0));
    chk("rst_act", 32'(bus.ch_active), 32'(0));
`ifdef TICK_GEN_SQWAVE_EN
    chk("rst_sq", 32'(bus.sq), 32'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    // ch0 inc=64: ticks every 4th edge
    wr(0, 64, 1'b1, 1'b0);
    chk("act_a", 32'(bus.ch_active), 32'(5'b00001));
    repeat (12) step(1'b0);

    // ch1 inc=96: ticks at 3,6,8 mod 8
    wr(1, 96, 1'b1, 1'b0);
    chk("act_b", 32'(bus.ch_active), 32'(5'b00011));
    for (int k = 1; k <= 16; k++) begin
      step(1'b0);
      chk("tick1_96", 32'(bus.tick[1]),
          32'(k % 8 == 3 || k % 8 == 6 || k % 8 == 0));
    end

    // isolation: ch1 off, ch2 inc=128, rewrite ch2
    wr(1, 0, 1'b0, 1'b0);
    wr(2, 128, 1'b1, 1'b0);
    chk("act_c", 32'(bus.ch_active), 32'(5'b00101));
    for (int k = 1; k <= 6; k++) begin
      step(1'b0);
      chk("tick2", 32'(bus.tick[2]), 32'(k % 2 == 0));
    end
    wr(2, 128, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0);
      chk("tick2_re", 32'(bus.tick[2]), 32'(k % 2 == 0));
    end

    // out-of-range channel: no change anywhere
    wr(5, 255, 1'b1, 1'b0);
    chk("act_oor", 32'(bus.ch_active), 32'(5'b00101));
    for (int k = 6; k <= 9; k++) begin
      step(1'b0);
      chk("tick2_oor", 32'(bus.tick[2]), 32'(k % 2 == 0));
      chk("oth_oor", 32'({bus.tick[4:3], bus.tick[1]}), 32'(0));
    end

    // sync with ch0=64, ch1=128, ch2=128
    wr(1, 128, 1'b1, 1'b0);
    step(1'b0);
    bus.sync = 1'b1;
    step(1'b1);
    bus.sync = 1'b0;
    chk("sync_clr", 32'(bus.tick), 32'(0));
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      ev = {1'b0, 1'b0, k % 2 == 0, k % 2 == 0, k % 4 == 0};
      chk("sync_al", 32'(bus.tick), 32'(ev));
    end

    // sync together with ch3 write
    step(1'b0);
    wr(3, 64, 1'b1, 1'b1);
    chk("act_d", 32'(bus.ch_active), 32'(5'b01111));
    chk("sw_clr", 32'(bus.tick), 32'(0));
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      ev = {1'b0, k % 4 == 0, k % 2 == 0, k % 2 == 0, k % 4 == 0};
      chk("sw_al", 32'(bus.tick), 32'(ev));
    end

    // async reset mid-run while ticks are high
    #2;
    rst = 1'b1;
    #1;
    run0 = 1'b0;
    chk("mrst_tick", 32'(bus.tick), 32'(0));
    chk("mrst_act", 32'(bus.ch_active), 32'(0));
`ifdef TICK_GEN_SQWAVE_EN
    chk("mrst_sq", 32'(bus.sq), 32'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0);
      chk("post_rst", 32'(bus.tick), 32'(0));
    end
    chk("post_act", 32'(bus.ch_active), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
